// File: rtl/decode_stage.sv
// RISC-V decode stage: combinational decode of the incoming word into a
// two-entry (main + skid) registered buffer with valid/ready handshakes.
package decode_stage_pkg;
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] alu;
    logic [2:0] load_flag;
    logic [1:0] store_flag;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic       rs2_en;
    logic       word_op;
    logic       illegal;
  } ctrl_t;
endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RV64 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      Rd_addr,
  output logic [4:0]      Rs1_addr,
  output logic [4:0]      Rs2_addr,
  output logic [4:0]      Alu_opr,
  output logic [2:0]      load_flag,
  output logic [1:0]      store_flag,
  output logic            reg_write_en,
  output logic            mem_write_en,
  output logic            mem_read_en,
  output logic            branch_en,
  output logic            jump_en,
  output logic            Rs2_en,
  output logic            word_op,
  output logic            illegal
);

  localparam bit IS64  = (XLEN == 64);
  localparam bit HAS64 = (RV64 != 0);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_XOR = 5'd3;
  localparam logic [4:0] ALU_SRL = 5'd4,  ALU_SRA = 5'd5,  ALU_OR = 5'd6,   ALU_AND = 5'd7;
  localparam logic [4:0] ALU_SLT = 5'd8,  ALU_SLTU = 5'd9, ALU_BEQ = 5'd10, ALU_BNE = 5'd11;
  localparam logic [4:0] ALU_BLT = 5'd12, ALU_BGE = 5'd13, ALU_BLTU = 5'd14, ALU_BGEU = 5'd15;
  localparam logic [4:0] ALU_JAL = 5'd16, ALU_JALR = 5'd17, ALU_LUI = 5'd18, ALU_AUIPC = 5'd19;
  localparam logic [4:0] ALU_NOP = 5'd31;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [1:0]      state_q, state_d;
  logic            accept, pop;
  logic            main_from_in, main_from_skid, skid_from_in;
  ctrl_t           dec, main_ctrl, skid_ctrl;
  logic [XLEN-1:0] dec_imm, main_imm, skid_imm, main_pc, skid_pc;
  logic            ok, wr;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        sll_ok, srx_ok, w_srx_ok;

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign f7    = in_inst[31:25];
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Shift-immediate upper bits: shamt[5] only exists on a 64-bit datapath
  assign sll_ok   = IS64 ? (in_inst[31:26] == 6'b0) : (f7 == 7'b0);
  assign srx_ok   = IS64 ? ({in_inst[31], in_inst[29:26]} == 5'b0)
                         : ({in_inst[31], in_inst[29:25]} == 6'b0);
  assign w_srx_ok = ({in_inst[31], in_inst[29:25]} == 6'b0);

  // Instruction decode
  always_comb begin
    dec     = '0;
    dec_imm = '0;
    ok      = 1'b0;
    wr      = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        ok      = 1'b1;
        wr      = 1'b1;
        dec.rd  = in_inst[11:7];
        dec.alu = (opc == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
        dec_imm = sext32(imm_u);
      end
      OPC_JAL: begin
        ok       = 1'b1;
        wr       = 1'b1;
        dec.jump = 1'b1;
        dec.rd   = in_inst[11:7];
        dec.alu  = ALU_JAL;
        dec_imm  = sext32(imm_j);
      end
      OPC_JALR: begin
        ok       = (f3 == 3'b000);
        wr       = 1'b1;
        dec.jump = 1'b1;
        dec.rd   = in_inst[11:7];
        dec.rs1  = in_inst[19:15];
        dec.alu  = ALU_JALR;
        dec_imm  = sext32(imm_i);
      end
      OPC_BRANCH: begin
        ok         = (f3[2:1] != 2'b01);
        dec.branch = 1'b1;
        dec.rs2_en = 1'b1;
        dec.rs1    = in_inst[19:15];
        dec.rs2    = in_inst[24:20];
        dec_imm    = sext32(imm_b);
        case (f3)
          3'b000:  dec.alu = ALU_BEQ;
          3'b001:  dec.alu = ALU_BNE;
          3'b100:  dec.alu = ALU_BLT;
          3'b101:  dec.alu = ALU_BGE;
          3'b110:  dec.alu = ALU_BLTU;
          default: dec.alu = ALU_BGEU;
        endcase
      end
      OPC_LOAD: begin
        wr           = 1'b1;
        dec.mem_read = 1'b1;
        dec.rd       = in_inst[11:7];
        dec.rs1      = in_inst[19:15];
        dec.alu      = ALU_ADD;
        dec_imm      = sext32(imm_i);
        case (f3)
          3'b000:  begin ok = 1'b1;  dec.load_flag = 3'd0; end
          3'b001:  begin ok = 1'b1;  dec.load_flag = 3'd1; end
          3'b010:  begin ok = 1'b1;  dec.load_flag = 3'd2; end
          3'b100:  begin ok = 1'b1;  dec.load_flag = 3'd3; end
          3'b101:  begin ok = 1'b1;  dec.load_flag = 3'd4; end
          3'b011:  begin ok = HAS64; dec.load_flag = 3'd5; end
          3'b110:  begin ok = HAS64; dec.load_flag = 3'd6; end
          default: ok = 1'b0;
        endcase
      end
      OPC_STORE: begin
        ok             = !f3[2] && (f3 != 3'b011 || HAS64);
        dec.mem_write  = 1'b1;
        dec.rs2_en     = 1'b1;
        dec.rs1        = in_inst[19:15];
        dec.rs2        = in_inst[24:20];
        dec.alu        = ALU_ADD;
        dec.store_flag = f3[1:0];
        dec_imm        = sext32(imm_s);
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        wr          = 1'b1;
        dec.word_op = (opc == OPC_OPIMM32);
        dec.rd      = in_inst[11:7];
        dec.rs1     = in_inst[19:15];
        dec_imm     = sext32(imm_i);
        case (f3)
          3'b001:  begin ok = dec.word_op ? (f7 == 7'b0) : sll_ok; dec.alu = ALU_SLL; end
          3'b101:  begin
            ok      = dec.word_op ? w_srx_ok : srx_ok;
            dec.alu = in_inst[30] ? ALU_SRA : ALU_SRL;
          end
          default: begin ok = !dec.word_op || f3 == 3'b000; dec.alu = alu_base(f3); end
        endcase
        if (dec.word_op && !HAS64) ok = 1'b0;
      end
      OPC_OP, OPC_OP32: begin
        wr          = 1'b1;
        dec.word_op = (opc == OPC_OP32);
        dec.rs2_en  = 1'b1;
        dec.rd      = in_inst[11:7];
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        if (f7 == 7'b0000000) begin
          ok      = !dec.word_op || f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101;
          dec.alu = alu_base(f3);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          ok      = 1'b1;
          dec.alu = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end
        if (dec.word_op && !HAS64) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    dec.reg_write = wr && (dec.rd != 5'd0);
    if (!ok) begin
      dec         = '0;
      dec.alu     = ALU_NOP;
      dec.illegal = 1'b1;
      dec_imm     = '0;
    end
  end

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Next occupancy and buffer load selects
  always_comb begin
    state_d        = state_q;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    case (state_q)
      S_EMPTY: if (accept) begin state_d = S_ONE; main_from_in = 1'b1; end
      S_ONE: begin
        if (accept && pop) main_from_in = 1'b1;
        else if (accept) begin state_d = S_TWO; skid_from_in = 1'b1; end
        else if (pop) state_d = S_EMPTY;
      end
      S_TWO:   if (pop) begin state_d = S_ONE; main_from_skid = 1'b1; end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  // Handshake flops and entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_ctrl <= '0;
      main_imm  <= '0;
      main_pc   <= '0;
      skid_ctrl <= '0;
      skid_imm  <= '0;
      skid_pc   <= '0;
    end else begin
      in_ready  <= (state_d != S_TWO);
      out_valid <= (state_d != S_EMPTY);
      if (main_from_in) begin
        main_ctrl <= dec;
        main_imm  <= dec_imm;
        main_pc   <= in_pc;
      end else if (main_from_skid) begin
        main_ctrl <= skid_ctrl;
        main_imm  <= skid_imm;
        main_pc   <= skid_pc;
      end
      if (skid_from_in) begin
        skid_ctrl <= dec;
        skid_imm  <= dec_imm;
        skid_pc   <= in_pc;
      end
    end
  end

  assign out_pc       = main_pc;
  assign imm          = main_imm;
  assign Rd_addr      = main_ctrl.rd;
  assign Rs1_addr     = main_ctrl.rs1;
  assign Rs2_addr     = main_ctrl.rs2;
  assign Alu_opr      = main_ctrl.alu;
  assign load_flag    = main_ctrl.load_flag;
  assign store_flag   = main_ctrl.store_flag;
  assign reg_write_en = main_ctrl.reg_write;
  assign mem_write_en = main_ctrl.mem_write;
  assign mem_read_en  = main_ctrl.mem_read;
  assign branch_en    = main_ctrl.branch;
  assign jump_en      = main_ctrl.jump;
  assign Rs2_en       = main_ctrl.rs2_en;
  assign word_op      = main_ctrl.word_op;
  assign illegal      = main_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed decode table, buffering corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_decode_stage;

  typedef struct packed {
    logic [4:0]  rd, rs1, rs2, alu;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic        rw, mw, mr, br, jp, r2, wo, il;
    logic [63:0] imm;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    exp_t        e;
    logic        il32;
  } vec_t;

  typedef struct {
    exp_t        e;
    logic [63:0] pc;
  } sb_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] in_inst = 32'h0;
  logic [63:0] in_pc = 64'h0, out_pc, imm;
  logic [4:0]  Rd_addr, Rs1_addr, Rs2_addr, Alu_opr;
  logic [2:0]  load_flag;
  logic [1:0]  store_flag;
  logic        reg_write_en, mem_write_en, mem_read_en, branch_en, jump_en, Rs2_en, word_op, illegal;

  logic        s32_in_ready, s32_out_valid;
  logic [31:0] s32_out_pc, s32_imm;
  logic [4:0]  s32_rd, s32_rs1, s32_rs2, s32_alu;
  logic [2:0]  s32_ld;
  logic [1:0]  s32_st;
  logic        s32_rw, s32_mw, s32_mr, s32_br, s32_jp, s32_r2, s32_wo, s32_il;

  int checks = 0, failures = 0;
  sb_t q[$];
  vec_t tbl[13];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .RV64(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .imm(imm), .Rd_addr(Rd_addr), .Rs1_addr(Rs1_addr), .Rs2_addr(Rs2_addr),
    .Alu_opr(Alu_opr), .load_flag(load_flag), .store_flag(store_flag),
    .reg_write_en(reg_write_en), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .branch_en(branch_en), .jump_en(jump_en), .Rs2_en(Rs2_en), .word_op(word_op),
    .illegal(illegal)
  );

  decode_stage #(.XLEN(32), .RV64(0)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s32_in_ready), .in_inst(in_inst),
    .in_pc(in_pc[31:0]), .flush(flush), .out_valid(s32_out_valid), .out_ready(out_ready),
    .out_pc(s32_out_pc), .imm(s32_imm), .Rd_addr(s32_rd), .Rs1_addr(s32_rs1), .Rs2_addr(s32_rs2),
    .Alu_opr(s32_alu), .load_flag(s32_ld), .store_flag(s32_st),
    .reg_write_en(s32_rw), .mem_write_en(s32_mw), .mem_read_en(s32_mr),
    .branch_en(s32_br), .jump_en(s32_jp), .Rs2_en(s32_r2), .word_op(s32_wo),
    .illegal(s32_il)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic exp_t snap();
    exp_t s;
    s.rd = Rd_addr;  s.rs1 = Rs1_addr; s.rs2 = Rs2_addr; s.alu = Alu_opr;
    s.ld = load_flag; s.st = store_flag;
    s.rw = reg_write_en; s.mw = mem_write_en; s.mr = mem_read_en; s.br = branch_en;
    s.jp = jump_en; s.r2 = Rs2_en; s.wo = word_op; s.il = illegal;
    s.imm = imm;
    return s;
  endfunction

  // flags = {rw, mw, mr, br, jp, r2, wo, il}
  function automatic exp_t mk(input int rd, input int rs1, input int rs2, input int alu,
                              input int ld, input int st, input logic [7:0] flags,
                              input logic [63:0] im);
    exp_t e;
    e.rd = 5'(rd); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2); e.alu = 5'(alu);
    e.ld = 3'(ld); e.st = 2'(st);
    {e.rw, e.mw, e.mr, e.br, e.jp, e.r2, e.wo, e.il} = flags;
    e.imm = im;
    return e;
  endfunction

  // Reference decode for XLEN=64, RV64=1
  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t e;
    logic ok, wr;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [63:0] im_i, im_s, im_b, im_u, im_j;
    int alu_tab[8];
    int ld_tab[8];
    alu_tab = '{0, 2, 8, 9, 3, 4, 6, 7};
    ld_tab  = '{0, 1, 2, 5, 3, 4, 6, -1};
    e = '0; ok = 1'b0; wr = 1'b0;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    im_i = {{52{i[31]}}, i[31:20]};
    im_s = {{52{i[31]}}, i[31:25], i[11:7]};
    im_b = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    im_u = {{32{i[31]}}, i[31:12], 12'h000};
    im_j = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    case (op)
      7'h37: begin ok = 1; wr = 1; e.rd = i[11:7]; e.alu = 5'd18; e.imm = im_u; end
      7'h17: begin ok = 1; wr = 1; e.rd = i[11:7]; e.alu = 5'd19; e.imm = im_u; end
      7'h6F: begin ok = 1; wr = 1; e.jp = 1; e.rd = i[11:7]; e.alu = 5'd16; e.imm = im_j; end
      7'h67: begin
        ok = (f3 == 0); wr = 1; e.jp = 1; e.rd = i[11:7]; e.rs1 = i[19:15];
        e.alu = 5'd17; e.imm = im_i;
      end
      7'h63: begin
        ok = (f3 != 2 && f3 != 3); e.br = 1; e.r2 = 1; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.imm = im_b;
        e.alu = 5'(10 + ((int'(f3) >= 4) ? int'(f3) - 2 : int'(f3)));
      end
      7'h03: begin
        ok = (ld_tab[f3] >= 0); wr = 1; e.mr = 1; e.rd = i[11:7]; e.rs1 = i[19:15];
        e.imm = im_i; e.ld = 3'(ld_tab[f3]);
      end
      7'h23: begin
        ok = (f3 <= 3); e.mw = 1; e.r2 = 1; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.imm = im_s; e.st = f3[1:0];
      end
      7'h13: begin
        wr = 1; e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = im_i;
        if (f3 == 1) begin ok = (i[31:26] == 0); e.alu = 5'd2; end
        else if (f3 == 5) begin
          ok = (i[31:26] == 0 || i[31:26] == 6'h10); e.alu = i[30] ? 5'd5 : 5'd4;
        end else begin ok = 1; e.alu = 5'(alu_tab[f3]); end
      end
      7'h33: begin
        wr = 1; e.r2 = 1; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        if (f7 == 0) begin ok = 1; e.alu = 5'(alu_tab[f3]); end
        else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin ok = 1; e.alu = (f3 == 0) ? 5'd1 : 5'd5; end
      end
      7'h1B: begin
        wr = 1; e.wo = 1; e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = im_i;
        if (f3 == 0) begin ok = 1; e.alu = 5'd0; end
        else if (f3 == 1) begin ok = (f7 == 0); e.alu = 5'd2; end
        else if (f3 == 5) begin ok = (f7 == 0 || f7 == 7'h20); e.alu = (f7 != 0) ? 5'd5 : 5'd4; end
      end
      7'h3B: begin
        wr = 1; e.wo = 1; e.r2 = 1; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        if (f7 == 0 && (f3 == 0 || f3 == 1 || f3 == 5)) begin ok = 1; e.alu = 5'(alu_tab[f3]); end
        else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin ok = 1; e.alu = (f3 == 0) ? 5'd1 : 5'd5; end
      end
      default: ok = 1'b0;
    endcase
    e.rw = wr && (e.rd != 0);
    if (!ok) begin
      e = '0; e.alu = 5'd31; e.il = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [6:0] ops[11];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B};
    r = $urandom;
    if ($urandom_range(0, 9) < 8) begin
      r[6:0] = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:26] = 6'h10;
        default: ;
      endcase
    end
    return r;
  endfunction

  initial begin
    tbl[0]  = '{32'h002081B3, mk(3, 1, 2, 0, 0, 0, 8'b1000_0100, 64'h0), 1'b0};
    tbl[1]  = '{32'hFFF00093, mk(1, 0, 0, 0, 0, 0, 8'b1000_0000, 64'hFFFF_FFFF_FFFF_FFFF), 1'b0};
    tbl[2]  = '{32'h00513423, mk(0, 2, 5, 0, 0, 3, 8'b0100_0100, 64'h8), 1'b1};
    tbl[3]  = '{32'hFFFFFFFF, mk(0, 0, 0, 31, 0, 0, 8'b0000_0001, 64'h0), 1'b1};
    tbl[4]  = '{32'h00000000, mk(0, 0, 0, 31, 0, 0, 8'b0000_0001, 64'h0), 1'b1};
    tbl[5]  = '{32'h800002B7, mk(5, 0, 0, 18, 0, 0, 8'b1000_0000, 64'hFFFF_FFFF_8000_0000), 1'b0};
    tbl[6]  = '{32'hFFDFF06F, mk(0, 0, 0, 16, 0, 0, 8'b0000_1000, 64'hFFFF_FFFF_FFFF_FFFC), 1'b0};
    tbl[7]  = '{32'h00208463, mk(0, 1, 2, 10, 0, 0, 8'b0001_0100, 64'h8), 1'b0};
    tbl[8]  = '{32'hFF83A303, mk(6, 7, 0, 0, 2, 0, 8'b1010_0000, 64'hFFFF_FFFF_FFFF_FFF8), 1'b0};
    tbl[9]  = '{32'h42125213, mk(4, 4, 0, 5, 0, 0, 8'b1000_0000, 64'h421), 1'b1};
    tbl[10] = '{32'h40C5853B, mk(10, 11, 12, 1, 0, 0, 8'b1000_0110, 64'h0), 1'b1};
    tbl[11] = '{32'h000280E7, mk(1, 5, 0, 17, 0, 0, 8'b1000_1000, 64'h0), 1'b0};
    tbl[12] = '{32'h022081B3, mk(0, 0, 0, 31, 0, 0, 8'b0000_0001, 64'h0), 1'b1};

    // Asynchronous reset state
    #1 rst = 1'b1;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_fields", snap(), '0);
    check("rst_pc", out_pc, 64'h0);
    in_valid = 1'b1;
    in_inst  = 32'h002081B3;
    cyc();
    check("rst_ignores_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    cyc();

    // Directed decode vectors, one per cycle, downstream always ready
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_inst  = tbl[i].inst;
      in_pc    = 64'h8000_0000_0000_1000 + 64'(i * 4);
      cyc();
      check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      check($sformatf("vec%0d_fields", i), snap(), tbl[i].e);
      check($sformatf("vec%0d_pc", i), out_pc, in_pc);
      check($sformatf("vec%0d_il32", i), s32_il, tbl[i].il32);
    end
    in_valid = 1'b0;
    cyc();
    check("drain_empty", out_valid, 1'b0);

    // Three back-to-back with downstream stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00000093;  // addi x1,x0,0
    cyc();
    check("bb_a_valid", {out_valid, in_ready}, 2'b11);
    in_inst = 32'h00000113;                   // addi x2,x0,0
    cyc();
    check("bb_full_ready", {out_valid, in_ready}, 2'b10);
    check("bb_head_a", Rd_addr, 5'd1);
    in_inst = 32'h00000193;                   // addi x3,x0,0
    cyc();
    check("bb_hold_ready", in_ready, 1'b0);
    check("bb_hold_a", Rd_addr, 5'd1);
    out_ready = 1'b1;
    cyc();
    check("bb_head_b", {out_valid, Rd_addr}, {1'b1, 5'd2});
    cyc();
    check("bb_head_c", {out_valid, Rd_addr}, {1'b1, 5'd3});
    in_valid = 1'b0;
    cyc();
    check("bb_empty", out_valid, 1'b0);

    // Flush while full, then flush racing an accept
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00000093;
    cyc(); cyc();
    check("fl_full", in_ready, 1'b0);
    flush = 1'b1;
    cyc();
    check("fl_two", {out_valid, in_ready}, 2'b01);
    flush = 1'b0;
    cyc();
    check("fl_refill", out_valid, 1'b1);
    flush = 1'b1;
    cyc();
    check("fl_accept_dropped", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    check("fl_stays_empty", out_valid, 1'b0);

    // Reset pulse between clock edges
    in_valid = 1'b1;
    cyc(); cyc();
    check("rp_full", {out_valid, in_ready}, 2'b10);
    #1 rst = 1'b1;
    #1;
    check("rp_async", {out_valid, in_ready}, 2'b01);
    check("rp_fields", snap(), '0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    cyc();
    check("rp_after", out_valid, 1'b0);

    // Randomized traffic against the queue model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      check("rnd_hs", {out_valid, in_ready}, {q.size() > 0, q.size() < 2});
      if (q.size() > 0) begin
        check("rnd_fields", snap(), q[0].e);
        check("rnd_pc", out_pc, q[0].pc);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = gen_inst();
      in_pc     = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      @(posedge clk);
      begin
        bit acc, pp;
        acc = in_valid && (q.size() < 2);
        pp  = (q.size() > 0) && out_ready;
        if (flush) q.delete();
        else begin
          if (pp) void'(q.pop_front());
          if (acc) q.push_back('{ref_dec(in_inst), in_pc});
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath/immediate width (32 or 64).
REQ-002 SHALL have parameter RV64, default 1, meaning 1 enables OP-IMM-32/OP-32 and 64-bit loads/stores.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  out  1  stage can accept (registered).
REQ-007 SHALL have port in_inst  in  32  instruction word.
REQ-008 SHALL have port in_pc  in  XLEN  instruction PC.
REQ-009 SHALL have port flush  in  1  discard all held entries.
REQ-010 SHALL have port out_valid  out  1  decoded entry valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts.
REQ-012 SHALL have ports out_pc  out  XLEN, imm  out  XLEN (sign-extended immediate).
REQ-013 SHALL have ports Rd_addr, Rs1_addr, Rs2_addr  out  5 each.
REQ-014 SHALL have ports Alu_opr  out  5; load_flag  out  3; store_flag  out  2.
REQ-015 SHALL have 1-bit outputs reg_write_en, mem_write_en, mem_read_en, branch_en, jump_en, Rs2_en, word_op, illegal.

Function
REQ-016 SHALL buffer up to two decoded entries (main + skid); states EMPTY, ONE, TWO.
REQ-017 Transitions: accept only -> +1; pop only -> -1; accept and pop together -> unchanged; flush -> EMPTY, overriding all.
REQ-018 accept = in_valid & in_ready; pop = out_valid & out_ready; out_valid = (state != EMPTY).
REQ-019 in_ready SHALL be registered and equal 0 exactly when the next state is TWO.
REQ-020 Latency: an instruction accepted at edge N SHALL appear on the outputs after edge N (zero bubbles when EMPTY).
REQ-021 Order SHALL be preserved; the skid entry moves to main on pop in state TWO.
REQ-022 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Decode SHALL cover LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, and, when RV64=1, OP-IMM-32/OP-32 (word_op=1).
REQ-024 Alu_opr codes: ADD0 SUB1 SLL2 XOR3 SRL4 SRA5 OR6 AND7 SLT8 SLTU9 BEQ10 BNE11 BLT12 BGE13 BLTU14 BGEU15 JAL16 JALR17 LUI18 AUIPC19 NOP31.
REQ-025 Loads/stores SHALL use Alu_opr=ADD; load_flag LB0 LH1 LW2 LBU3 LHU4 LD5 LWU6; store_flag SB0 SH1 SW2 SD3.
REQ-026 I/S/B/U/J immediates SHALL be sign-extended to XLEN; unused register fields SHALL be driven 0 (never Z/X).
REQ-027 SRAI SHALL be func3=101 with inst[30]=1; shamt is 6 bits if XLEN=64, otherwise inst[25]=1 is illegal.
REQ-028 Unknown opcode/func3/func7, LD/SD/LWU with RV64=0, or inst[1:0]!=11 SHALL set illegal=1, all enables 0, Alu_opr=31.
REQ-029 JAL/JALR SHALL set jump_en=1, reg_write_en=1 (unless rd=0); branches set branch_en=1, Rs2_en=1.
REQ-030 reg_write_en SHALL be 0 whenever Rd_addr=0.
REQ-031 An instruction accepted in a flush cycle SHALL be discarded.

Reset
REQ-032 On rst assertion, asynchronously: state EMPTY, out_valid 0, in_ready 1, all decoded outputs 0.
REQ-033 Reset mid-operation SHALL discard held entries; in_valid is ignored while rst=1.

Verification
REQ-034 0x002081B3 (add x3,x1,x2) -> next cycle out_valid=1, Rd=3, Rs1=1, Rs2=2, Alu_opr=0, reg_write_en=1, Rs2_en=1.
REQ-035 0xFFF00093 (addi x1,x0,-1), XLEN=64 -> imm=0xFFFFFFFFFFFFFFFF, Alu_opr=0, Rs2_en=0, Rs2_addr=0.
REQ-036 0x00513423 (sd x5,8(x2)) -> mem_write_en=1, store_flag=3, imm=8, reg_write_en=0; with RV64=0 -> illegal=1.
REQ-037 out_ready=0, three back-to-back instructions -> first two accepted, in_ready=0, third held; out_ready=1 -> all three emerge in order.
REQ-038 State TWO + flush -> out_valid=0 next cycle; rst pulse mid-stream -> out_valid=0 immediately, no clock needed.
REQ-039 0xFFFFFFFF and 0x00000000 -> illegal=1, all enables 0, Alu_opr=31.
